// File: rtl/xulie_seq_ctrl.sv
// Word-level sequencer for an external serial "1110" Moore detector: shifts each word in,
// counts hits, returns the count over a handshake. Define XULIE_LSB_FIRST_EN to shift LSB first.
module xulie_seq_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [WORD_W-1:0] In_data,
  output logic              Det_din,
  output logic              Det_rst_n,
  input  logic              Det_dout,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CNT_W-1:0]  Out_count,
  output logic [CNT_W-1:0]  Total_count,
  output logic              Total_sat,
  input  logic              Total_clr
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              det_din_q, det_din_d;
  logic              det_rst_n_q, det_rst_n_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              sat_q, sat_d;

  logic              accept;
  logic              resp_entry;
  logic [CNT_W-1:0]  word_sum;
  logic [CNT_W:0]    total_sum;

  // in_ready_q is only ever set while in IDLE, so it doubles as the state qualifier.
  assign accept     = In_valid && in_ready_q;
  assign resp_entry = (state_q == FLUSH);
  assign word_sum   = word_cnt_q + CNT_W'(Det_dout);
  assign total_sum  = {1'b0, total_q} + {1'b0, word_sum};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_cnt_d  = word_cnt_q;
    in_ready_d  = 1'b0;
    det_din_d   = det_din_q;
    det_rst_n_d = det_rst_n_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    total_d     = total_q;
    sat_d       = sat_q;

    unique case (state_q)
      IDLE: begin
        // Rises one cycle after entering IDLE, giving the post-response bubble.
        in_ready_d = !accept;
        if (accept) begin
`ifdef XULIE_LSB_FIRST_EN
          det_din_d = In_data[0];
          shift_d   = {1'b0, In_data[WORD_W-1:1]};
`else
          det_din_d = In_data[WORD_W-1];
          shift_d   = {In_data[WORD_W-2:0], 1'b0};
`endif
          det_rst_n_d = 1'b1;
          word_cnt_d  = '0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        word_cnt_d = word_sum;
        if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
          det_din_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef XULIE_LSB_FIRST_EN
          det_din_d = shift_q[0];
          shift_d   = {1'b0, shift_q[WORD_W-1:1]};
`else
          det_din_d = shift_q[WORD_W-1];
          shift_d   = {shift_q[WORD_W-2:0], 1'b0};
`endif
        end
      end
      FLUSH: begin
        // Dout now reflects the final bit; fold it in on the way out.
        word_cnt_d  = word_sum;
        out_count_d = word_sum;
        out_valid_d = 1'b1;
        det_rst_n_d = 1'b0;
        det_din_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (Out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resp_entry) begin
      if (Total_clr) begin
        total_d = word_sum;
        sat_d   = 1'b0;
      end else if (total_sum[CNT_W]) begin
        total_d = '1;
        sat_d   = 1'b1;
      end else begin
        total_d = total_sum[CNT_W-1:0];
      end
    end else if (Total_clr) begin
      total_d = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      det_din_q   <= 1'b0;
      det_rst_n_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      total_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      word_cnt_q  <= word_cnt_d;
      in_ready_q  <= in_ready_d;
      det_din_q   <= det_din_d;
      det_rst_n_q <= det_rst_n_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      total_q     <= total_d;
      sat_q       <= sat_d;
    end
  end

  assign In_ready    = in_ready_q;
  assign Det_din     = det_din_q;
  assign Det_rst_n   = det_rst_n_q;
  assign Out_valid   = out_valid_q;
  assign Out_count   = out_count_q;
  assign Total_count = total_q;
  assign Total_sat   = sat_q;

endmodule
